// File: rtl/upcc_ctrl_if.sv
// Request/grant bundle between the requesting control logic and upcc_ctrl.
// The controller takes the slave modport; the requester side takes master.
interface upcc_ctrl_if #(
    parameter int unsigned STEPW = 4
);
    logic [1:0]       inreq;
    logic [1:0]       inup;
    logic [STEPW-1:0] insteps0;
    logic [STEPW-1:0] insteps1;
    logic [1:0]       outgnt;
    logic [1:0]       outdone;
    logic [1:0]       outea;
    logic             outbusy;

    modport master (
        output inreq, inup, insteps0, insteps1,
        input  outgnt, outdone, outea, outbusy
    );

    modport slave (
        input  inreq, inup, insteps0, insteps1,
        output outgnt, outdone, outea, outbusy
    );
endinterface

// File: rtl/upcc_ctrl.sv
// Round-robin sequencer owning the 2-bit up/down counter state register.
// A granted requester gets its latched step count applied one step per clock.
module upcc_ctrl #(
    parameter int unsigned STEPW = 4
) (
    input  logic         inclk,
    input  logic         inrst_n,
    upcc_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [1:0]       ea_q, ea_d;
    logic [1:0]       gnt_q, gnt_d;
    logic [STEPW-1:0] rem_q, rem_d;
    logic             up_q, up_d;
    logic             lp_q, lp_d;
    logic             win;

    // On contention the requester that was not served last wins.
    always_comb begin
        if (bus.inreq == 2'b11) begin
            win = ~lp_q;
        end else begin
            win = bus.inreq[1];
        end
    end

    always_comb begin
        state_d = state_q;
        ea_d    = ea_q;
        gnt_d   = gnt_q;
        rem_d   = rem_q;
        up_d    = up_q;
        lp_d    = lp_q;
        case (state_q)
            StIdle: begin
                if (|bus.inreq) begin
                    gnt_d   = win ? 2'b10 : 2'b01;
                    up_d    = bus.inup[win];
                    rem_d   = win ? bus.insteps1 : bus.insteps0;
                    state_d = (rem_d != '0) ? StRun : StDone;
                end
            end
            StRun: begin
                ea_d  = up_q ? ea_q + 2'd1 : ea_q - 2'd1;
                rem_d = rem_q - STEPW'(1);
                if (rem_q == STEPW'(1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                lp_d    = gnt_q[1];
                gnt_d   = '0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge inclk or negedge inrst_n) begin
        if (!inrst_n) begin
            state_q <= StIdle;
            ea_q    <= '0;
            gnt_q   <= '0;
            rem_q   <= '0;
            up_q    <= 1'b0;
            lp_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            ea_q    <= ea_d;
            gnt_q   <= gnt_d;
            rem_q   <= rem_d;
            up_q    <= up_d;
            lp_q    <= lp_d;
        end
    end

    assign bus.outgnt  = gnt_q;
    assign bus.outdone = (state_q == StDone) ? gnt_q : 2'b00;
    assign bus.outea   = ea_q;
    assign bus.outbusy = (state_q != StIdle);
endmodule
